des_round_ctrl: RTL and testbench



---
 rtl/des_pkg.sv | 58 +++++
 rtl/des_round_ctrl_if.sv | 32 +++
 rtl/des_shift_sched.sv | 27 ++
 rtl/des_round_ctrl.sv | 108 ++++++++++
 tb/tb_des_round_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round controller.
// Holds the FSM state encoding, the fixed round count, the FIPS 46-3
// encrypt key-rotation schedule and the registered output bundle.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;
  localparam int unsigned RND_W      = 5;
  localparam int unsigned SHIFT_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Encrypt (left-rotate) amounts for rounds 1..16.
  localparam logic [SHIFT_W-1:0] KEY_SHIFT [1:DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Registered control outputs presented to the datapath.
  typedef struct packed {
    logic               in_ready;
    logic               busy;
    logic               ld;
    logic               round_en;
    logic [RND_W-1:0]   round_idx;
    logic [SHIFT_W-1:0] shift_amt;
    logic               shift_left;
    logic               last_round;
    logic               out_valid;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_OUT_RST = '{
    in_ready:   1'b1,
    busy:       1'b0,
    ld:         1'b0,
    round_en:   1'b0,
    round_idx:  '0,
    shift_amt:  '0,
    shift_left: 1'b1,
    last_round: 1'b0,
    out_valid:  1'b0
  };

  // Encrypt schedule lookup; rounds outside 1..16 rotate by zero.
  function automatic logic [SHIFT_W-1:0] key_shift(input logic [RND_W-1:0] rnd);
    logic [SHIFT_W-1:0] amt;
    amt = '0;
    if ((rnd >= RND_W'(1)) && (rnd <= RND_W'(DES_ROUNDS))) begin
      amt = KEY_SHIFT[rnd];
    end
    return amt;
  endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// Handshake and datapath-control bundle of the DES round controller.
// slave : controller side (des_round_ctrl).
// master: environment side (upstream producer, downstream consumer, datapath).
interface des_round_ctrl_if;
  import des_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               decrypt;
  logic               ld;
  logic               round_en;
  logic [RND_W-1:0]   round_idx;
  logic [SHIFT_W-1:0] shift_amt;
  logic               shift_left;
  logic               last_round;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport slave (
    input  in_valid, decrypt, out_ready,
    output in_ready, ld, round_en, round_idx, shift_amt, shift_left,
           last_round, out_valid, busy
  );

  modport master (
    output in_valid, decrypt, out_ready,
    input  in_ready, ld, round_en, round_idx, shift_amt, shift_left,
           last_round, out_valid, busy
  );

endinterface

// File: rtl/des_shift_sched.sv
// Key-schedule rotation decode for one DES round.
//   round_idx   in : round number 1..16 (anything else gives no shift)
//   dir         in : 0 = encrypt, 1 = decrypt
//   shift_amt_c out: C/D rotate amount
//   shift_left_c out: 1 = rotate left
module des_shift_sched
  import des_pkg::*;
(
  input  logic [RND_W-1:0]   round_idx,
  input  logic               dir,
  output logic [SHIFT_W-1:0] shift_amt_c,
  output logic               shift_left_c
);

  // Decrypt walks the encrypt table backwards (18 - round); round 1 uses
  // C16/D16 == C0/D0 directly, so it does not rotate.
  always_comb begin
    shift_amt_c  = '0;
    shift_left_c = ~dir;
    if (!dir) begin
      shift_amt_c = key_shift(round_idx);
    end else if (round_idx != RND_W'(1)) begin
      shift_amt_c = key_shift(RND_W'(DES_ROUNDS + 2) - round_idx);
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for an iterative single-round DES datapath.
// Accepts a block on in_valid/in_ready, strobes ld for one cycle, runs 16
// round-enable cycles with the key rotation for the latched direction,
// then holds out_valid until out_ready.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : des_round_ctrl_if.slave (handshakes and datapath controls)
// Every output is a flop loaded from the next-state decode, so nothing on
// the bus has a combinational path from in_valid or out_ready.
module des_round_ctrl
  import des_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  des_round_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic               dir_q, dir_d;
  ctrl_out_t          out_q, out_d;
  logic [SHIFT_W-1:0] sched_amt_c;
  logic               sched_left_c;

  // Rotation for the round about to be presented.
  des_shift_sched u_sched (
    .round_idx    (rnd_d),
    .dir          (dir_d),
    .shift_amt_c  (sched_amt_c),
    .shift_left_c (sched_left_c)
  );

  // State, round counter, direction and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= CTRL_OUT_RST;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    dir_d   = dir_q;
    out_d   = CTRL_OUT_RST;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          dir_d   = bus.decrypt;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rnd_d   = RND_W'(1);
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (rnd_q == RND_W'(DES_ROUNDS)) begin
          rnd_d   = '0;
          state_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        rnd_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    out_d.in_ready  = (state_d == ST_IDLE);
    out_d.busy      = (state_d != ST_IDLE);
    out_d.ld        = (state_d == ST_LOAD);
    out_d.out_valid = (state_d == ST_DONE);
    if (state_d == ST_ROUND) begin
      out_d.round_en   = 1'b1;
      out_d.round_idx  = rnd_d;
      out_d.shift_amt  = sched_amt_c;
      out_d.shift_left = sched_left_c;
      out_d.last_round = (rnd_d == RND_W'(DES_ROUNDS));
    end
  end

  assign bus.in_ready   = out_q.in_ready;
  assign bus.busy       = out_q.busy;
  assign bus.ld         = out_q.ld;
  assign bus.round_en   = out_q.round_en;
  assign bus.round_idx  = out_q.round_idx;
  assign bus.shift_amt  = out_q.shift_amt;
  assign bus.shift_left = out_q.shift_left;
  assign bus.last_round = out_q.last_round;
  assign bus.out_valid  = out_q.out_valid;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl. A phase-count model (0 idle,
// 1 load, 2..17 rounds 1..16, 18 done) predicts every output each cycle.
module tb_des_round_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  des_round_ctrl_if bus();

  des_round_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int enc_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_tab [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int   m_phase = 0;
  logic m_dir   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] pack_vec(input logic ir, input logic ld, input logic re,
                                           input int idx, input int amt, input logic sl,
                                           input logic lr, input logic ov, input logic bz);
    return {ir, ld, re, 5'(idx), 2'(amt), sl, lr, ov, bz};
  endfunction

  function automatic logic [13:0] act_vec();
    return {bus.in_ready, bus.ld, bus.round_en, bus.round_idx, bus.shift_amt,
            bus.shift_left, bus.last_round, bus.out_valid, bus.busy};
  endfunction

  function automatic logic [13:0] exp_vec();
    int r;
    if (m_phase == 0) return pack_vec(1, 0, 0, 0, 0, 1, 0, 0, 0);
    if (m_phase == 1) return pack_vec(0, 1, 0, 0, 0, 1, 0, 0, 1);
    if (m_phase <= 17) begin
      r = m_phase - 1;
      return pack_vec(0, 0, 1, r, m_dir ? dec_tab[r-1] : enc_tab[r-1], !m_dir,
                      r == 16, 0, 1);
    end
    return pack_vec(0, 0, 0, 0, 0, 1, 0, 1, 1);
  endfunction

  // Apply inputs for one clock, advance the model, check at the falling edge.
  task automatic cycle(input logic iv, input logic dec, input logic ordy);
    bus.in_valid  = iv;
    bus.decrypt   = dec;
    bus.out_ready = ordy;
    @(posedge clk);
    if (m_phase == 0) begin
      if (iv) begin
        m_phase = 1;
        m_dir   = dec;
      end
    end else if (m_phase < 18) begin
      m_phase++;
    end else if (ordy) begin
      m_phase = 0;
    end
    @(negedge clk);
    check_eq($sformatf("trace_ph%0d", m_phase), 32'(act_vec()), 32'(exp_vec()));
  endtask

  // One block from an idle controller; noise on in_valid/decrypt while busy.
  // Leaves the controller in DONE with out_ready low.
  task automatic run_block(input logic dec, input string tag);
    int lat;
    int sum;
    int exp_sum;
    exp_sum = 0;
    for (int i = 0; i < 16; i++) exp_sum += dec ? dec_tab[i] : enc_tab[i];
    check_eq({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    cycle(1'b1, dec, 1'b0);
    lat = 1;
    sum = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.round_en) sum += int'(bus.shift_amt);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd18);
    check_eq({tag, "_shift_sum"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.decrypt   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check_eq("reset_vec", 32'(act_vec()), 32'(pack_vec(1, 0, 0, 0, 0, 1, 0, 0, 0)));
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    // Encrypt, then backpressure in DONE for 5 cycles.
    run_block(1'b0, "enc");
    for (int i = 0; i < 5; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("bp_release_idle", 32'(bus.in_ready), 32'd1);

    // Decrypt immediately after the idle cycle.
    run_block(1'b1, "dec");
    cycle(1'b0, 1'b0, 1'b1);

    // Asynchronous reset at round 7.
    cycle(1'b1, 1'b0, 1'b1);
    repeat (7) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    check_eq("pre_rst_round", 32'(bus.round_idx), 32'd7);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'(act_vec()), 32'(pack_vec(1, 0, 0, 0, 0, 1, 0, 0, 0)));
    m_phase = 0;
    m_dir   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_held", 32'(act_vec()), 32'(exp_vec()));
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    run_block(1'b1, "post_rst");
    cycle(1'b0, 1'b0, 1'b1);

    // Random traffic on all three inputs.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
